wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Round-robin Wishbone (pipelined) arbiter that lets several bus masters share one master port of the Wishbone bus/address decoder. It sits between the CPU, DMA and debug masters and the decoder's master interface. A master holds ownership for its whole CYC, or while LOCK is asserted. Non-owners see STALL and never see ACK.

Parameters:
WB_DATA_WIDTH, 8, data bus width in bits
WB_ADDR_WIDTH, 16, address bus width in bits
WB_NUM_MASTERS, 2, number of requesting masters (1..8)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
mstr_cyc_i  in  WB_NUM_MASTERS  per-master CYC (bus request)
mstr_lock_i  in  WB_NUM_MASTERS  per-master LOCK
mstr_stb_i  in  WB_NUM_MASTERS  per-master STB
mstr_we_i  in  WB_NUM_MASTERS  per-master WE
mstr_adr_i  in  WB_ADDR_WIDTH*WB_NUM_MASTERS  packed addresses, master i at [i*W +: W]
mstr_dat_i  in  WB_DATA_WIDTH*WB_NUM_MASTERS  packed write data
mstr_stall_o  out  WB_NUM_MASTERS  per-master STALL
mstr_ack_o  out  WB_NUM_MASTERS  per-master ACK
mstr_dat_o  out  WB_DATA_WIDTH*WB_NUM_MASTERS  packed read data
bus_cyc_o, bus_lock_o, bus_stb_o, bus_we_o  out  1 each  to shared bus master port
bus_adr_o  out  WB_ADDR_WIDTH  to shared bus
bus_dat_o  out  WB_DATA_WIDTH  to shared bus
bus_stall_i, bus_ack_i  in  1 each  from shared bus
bus_dat_i  in  WB_DATA_WIDTH  from shared bus
grant_o  out  WB_NUM_MASTERS  one-hot current owner (all-zero when idle)

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- State: registered grant (one-hot or zero) plus last-owner pointer. Reset: grant=0, pointer=WB_NUM_MASTERS-1, so master 0 has top priority first.
- IDLE (grant=0): if any mstr_cyc_i is set, the grant register loads the first requester searching from pointer+1 upward with wrap. Ownership therefore starts 1 cycle after CYC rises. Pointer updates to the new owner.
- OWNED: held while owner's cyc or lock is 1.
- Release: owner's cyc=0 and lock=0 in a cycle. Next cycle the grant goes to the next round-robin requester, or to 0 if none. No dead cycle is inserted when another master is waiting.
- Requests from other masters never preempt the owner.
- Mux, combinational from the grant register:
  - bus_cyc_o/lock/stb = owner's signal AND grant; all 0 when idle.
  - bus_we/adr/dat = owner's signals; 0 when idle.
- Return path:
  - Owner: mstr_ack_o = bus_ack_i, mstr_stall_o = bus_stall_i, mstr_dat_o slice = bus_dat_i.
  - Every non-owner: ack=0, stall=1, dat=0.
  - When idle: all stall=1.
- Reset mid-cycle: grant is dropped next edge, bus_cyc_o is deasserted and any in-flight ACK is discarded. Masters must be reset together.
- CYC dropped with ACKs outstanding is a master protocol violation. The arbiter releases regardless.
- WB_NUM_MASTERS=1: degenerates to a registered grant with 1-cycle acquire latency.

Test Plan:
- Reset, no requests -> grant_o=00, bus_cyc_o=0, mstr_stall_o=11, mstr_ack_o=00.
- M0 and M1 raise cyc in the same cycle after reset -> grant_o=01 next cycle. M0 releases -> grant_o=10 on the following cycle with no idle gap.
- M1 owns and issues 3 pipelined reads (adr 0x0010..0x0012, slave returns 0xA1,0xA2,0xA3). M0 requests mid-burst -> M0 sees stall=1, ack=0 throughout. M1 receives all 3 ACKs with correct data. M0 is granted after M1 drops cyc.
- M0 holds lock=1, drops cyc for 2 cycles, then reasserts it while M1 requests -> grant stays 01 across the gap. M1 is granted only after M0 drops both cyc and lock.
- M0 and M1 request continuously with 1-transfer cycles -> grant alternates 01,10,01,10. Neither master is granted twice in a row while the other waits.
- rst_i asserted while M1 owns with stb=1 -> next cycle grant_o=00, bus_cyc_o=0, pointer=last index. The first post-reset request from both masters grants M0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for pipelined Wishbone masters sharing one bus master port.
// Ownership is registered and lasts for the owner's whole CYC, or while it holds LOCK.
module wb_arbiter #(
  parameter int WB_DATA_WIDTH  = 8,
  parameter int WB_ADDR_WIDTH  = 16,
  parameter int WB_NUM_MASTERS = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_cyc_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_lock_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_stb_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_we_i,
  input  logic [WB_ADDR_WIDTH*WB_NUM_MASTERS-1:0] mstr_adr_i,
  input  logic [WB_DATA_WIDTH*WB_NUM_MASTERS-1:0] mstr_dat_i,
  output logic [WB_NUM_MASTERS-1:0]               mstr_stall_o,
  output logic [WB_NUM_MASTERS-1:0]               mstr_ack_o,
  output logic [WB_DATA_WIDTH*WB_NUM_MASTERS-1:0] mstr_dat_o,
  output logic                                    bus_cyc_o,
  output logic                                    bus_lock_o,
  output logic                                    bus_stb_o,
  output logic                                    bus_we_o,
  output logic [WB_ADDR_WIDTH-1:0]                bus_adr_o,
  output logic [WB_DATA_WIDTH-1:0]                bus_dat_o,
  input  logic                                    bus_stall_i,
  input  logic                                    bus_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]                bus_dat_i,
  output logic [WB_NUM_MASTERS-1:0]               grant_o
);
  localparam int NM = WB_NUM_MASTERS;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0] grant_q, nxt_grant;
  logic [PW-1:0] ptr_q, nxt_ptr;
  logic          found;
  int            idx;

  // Re-arbitrate only when idle or when the owner has dropped both CYC and LOCK.
  always_comb begin
    nxt_grant = grant_q;
    nxt_ptr   = ptr_q;
    found     = 1'b0;
    idx       = 0;
    if (((mstr_cyc_i | mstr_lock_i) & grant_q) == '0) begin
      nxt_grant = '0;
      for (int k = 1; k <= NM; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NM) idx = idx - NM;
        for (int j = 0; j < NM; j++) begin
          if (!found && j == idx && mstr_cyc_i[j]) begin
            found        = 1'b1;
            nxt_grant[j] = 1'b1;
            nxt_ptr      = PW'(j);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= '0;
      ptr_q   <= PW'(NM - 1);
    end else begin
      grant_q <= nxt_grant;
      ptr_q   <= nxt_ptr;
    end
  end

  assign grant_o    = grant_q;
  assign bus_cyc_o  = |(mstr_cyc_i & grant_q);
  assign bus_lock_o = |(mstr_lock_i & grant_q);
  assign bus_stb_o  = |(mstr_stb_i & grant_q);
  assign bus_we_o   = |(mstr_we_i & grant_q);

  always_comb begin
    bus_adr_o = '0;
    bus_dat_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) begin
        bus_adr_o = mstr_adr_i[i*AW +: AW];
        bus_dat_o = mstr_dat_i[i*DW +: DW];
      end
    end
  end

  // Non-owners (and everyone while idle) are held off with STALL.
  assign mstr_stall_o = ~grant_q | {NM{bus_stall_i}};
  assign mstr_ack_o   = grant_q & {NM{bus_ack_i}};

  always_comb begin
    mstr_dat_o = '0;
    for (int i = 0; i < NM; i++)
      if (grant_q[i]) mstr_dat_o[i*DW +: DW] = bus_dat_i;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter, checked against an owner/round-robin model.
module tb_wb_arbiter;
  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cyc, lock, stb, we;
  logic [AW*N-1:0] adr;
  logic [DW*N-1:0] wdat;
  logic [N-1:0]    stall_o, ack_o;
  logic [DW*N-1:0] rdat_o;
  logic            bcyc, block, bstb, bwe;
  logic [AW-1:0]   badr;
  logic [DW-1:0]   bdat_o;
  logic            bstall, back;
  logic [DW-1:0]   bdat_i;
  logic [N-1:0]    grant;

  int checks = 0;
  int errors = 0;
  int owner, last, prev;

  always #5 clk = ~clk;

  wb_arbiter #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_NUM_MASTERS(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .mstr_cyc_i(cyc), .mstr_lock_i(lock), .mstr_stb_i(stb), .mstr_we_i(we),
    .mstr_adr_i(adr), .mstr_dat_i(wdat),
    .mstr_stall_o(stall_o), .mstr_ack_o(ack_o), .mstr_dat_o(rdat_o),
    .bus_cyc_o(bcyc), .bus_lock_o(block), .bus_stb_o(bstb), .bus_we_o(bwe),
    .bus_adr_o(badr), .bus_dat_o(bdat_o),
    .bus_stall_i(bstall), .bus_ack_i(back), .bus_dat_i(bdat_i),
    .grant_o(grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs follow directly from who owns the bus.
  task automatic check_all();
    logic [N-1:0]    e_grant, e_stall, e_ack;
    logic [DW*N-1:0] e_rdat;
    bit              own;
    own     = (owner >= 0);
    e_grant = '0;
    e_stall = '1;
    e_ack   = '0;
    e_rdat  = '0;
    if (own) begin
      e_grant[owner]           = 1'b1;
      e_stall[owner]           = bstall;
      e_ack[owner]             = back;
      e_rdat[owner*DW +: DW]   = bdat_i;
    end
    chk("grant",    32'(grant),   32'(e_grant));
    chk("bus_cyc",  32'(bcyc),    own ? 32'(cyc[owner])  : 0);
    chk("bus_lock", 32'(block),   own ? 32'(lock[owner]) : 0);
    chk("bus_stb",  32'(bstb),    own ? 32'(stb[owner])  : 0);
    chk("bus_we",   32'(bwe),     own ? 32'(we[owner])   : 0);
    chk("bus_adr",  32'(badr),    own ? 32'(adr[owner*AW +: AW])  : 0);
    chk("bus_dat",  32'(bdat_o),  own ? 32'(wdat[owner*DW +: DW]) : 0);
    chk("stall",    32'(stall_o), 32'(e_stall));
    chk("ack",      32'(ack_o),   32'(e_ack));
    chk("rdat",     32'(rdat_o),  32'(e_rdat));
  endtask

  // Reference: keep the owner while it holds cyc or lock, else next requester after last.
  task automatic model_update();
    int m;
    if (rst) begin
      owner = -1;
      last  = N - 1;
    end else if (owner < 0 || (!cyc[owner] && !lock[owner])) begin
      owner = -1;
      for (int k = 1; k <= N; k++) begin
        m = (last + k) % N;
        if (owner < 0 && cyc[m]) owner = m;
      end
      if (owner >= 0) last = owner;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1; cyc = '0; lock = '0; stb = '0; we = '0; adr = '0; wdat = '0;
    bstall = 1'b0; back = 1'b0; bdat_i = '0;
    owner = -1; last = N - 1; prev = -1;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_stall", 32'(stall_o), 32'h3);

    // Simultaneous request: M0 first, then M1 with no idle gap.
    cyc = 2'b11;
    step();
    chk("both_m0", 32'(grant), 32'h1);
    cyc = 2'b10;
    step();
    chk("handover_m1", 32'(grant), 32'h2);

    // M1 burst of 3 reads while M0 waits.
    cyc = 2'b11; stb = 2'b10; adr[AW +: AW] = 16'h0010;
    step();
    adr[AW +: AW] = 16'h0011; back = 1'b1; bdat_i = 8'hA1;
    step();
    chk("burst_m0_stall", 32'(stall_o[0]), 1);
    adr[AW +: AW] = 16'h0012; bdat_i = 8'hA2;
    step();
    chk("burst_m1_dat", 32'(rdat_o[DW +: DW]), 32'hA2);
    stb = 2'b00; bdat_i = 8'hA3;
    step();
    chk("burst_m0_noack", 32'(ack_o[0]), 0);
    back = 1'b0; cyc = 2'b01;
    step();
    chk("after_burst_m0", 32'(grant), 32'h1);

    // Lock holds M0 across a CYC gap.
    lock = 2'b01;
    step();
    cyc = 2'b10;
    step();
    step();
    chk("lock_hold", 32'(grant), 32'h1);
    cyc = 2'b11;
    step();
    cyc = 2'b10; lock = 2'b00;
    step();
    chk("lock_release", 32'(grant), 32'h2);
    cyc = 2'b00;
    step();

    // Continuous requests with single-transfer cycles alternate owners.
    cyc = 2'b11;
    step();
    prev = owner;
    for (int i = 0; i < 8; i++) begin
      cyc = 2'b11;
      cyc[owner] = 1'b0;
      step();
      chk("alternate", 32'(owner != prev), 1);
      prev = owner;
    end
    cyc = 2'b00;
    step();

    // Reset while M1 owns with STB high.
    cyc = 2'b10; stb = 2'b10;
    step();
    rst = 1'b1;
    step();
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_cyc", 32'(bcyc), 0);
    rst = 1'b0; cyc = 2'b11; stb = 2'b00;
    step();
    chk("postrst_m0", 32'(grant), 32'h1);
    cyc = 2'b00;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc    = N'($urandom);
      lock   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      stb    = N'($urandom);
      we     = N'($urandom);
      adr    = (AW*N)'({$urandom, $urandom});
      wdat   = (DW*N)'($urandom);
      bstall = 1'($urandom);
      back   = 1'($urandom);
      bdat_i = DW'($urandom);
      rst    = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
